// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC owner and redirect controller between the execute and fetch stages.
// Optional redirect counter enabled by defining PC_REDIRECT_PERF_EN.
module pc_redirect_ctrl #(
    parameter int                 WIDTH        = 64,
    parameter logic [WIDTH-1:0]   RESET_PC     = WIDTH'(64'h0000_0000_8000_0000),
    parameter int                 FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_jump_en_i,
    input  logic [WIDTH-1:0] branch_jump_addr_i,
    input  logic             hold_pipeline_en_i,
    input  logic             halt_i,
    input  logic             fetch_ready_i,
    output logic             fetch_req_o,
    output logic [WIDTH-1:0] fetch_pc_o,
    output logic             flush_o,
    output logic             stall_o,
    output logic             misalign_o,
    output logic             halted_o,
    output logic [31:0]      redirect_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             req_q, req_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;
    logic             halted_q, halted_d;
    logic [3:0]       cnt_q, cnt_d;

    // Fetch handshake: a request is consumed on an edge where fetch_req_o & fetch_ready_i;
    // an unconsumed request keeps fetch_pc_o stable unless a redirect or halt overrides it.
    logic             accept;
    logic [WIDTH-1:0] target_pc;

    assign accept    = req_q & fetch_ready_i;
    assign target_pc = {branch_jump_addr_i[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_i)                state_d = ST_HALT;
                else if (branch_jump_en_i) state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (halt_i)              state_d = ST_HALT;
                else if (cnt_q == 4'd0)  state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        req_d      = req_q;
        flush_d    = flush_q;
        misalign_d = 1'b0;
        halted_d   = halted_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_i) begin
                    req_d    = 1'b0;
                    flush_d  = 1'b1;
                    halted_d = 1'b1;
                end else if (branch_jump_en_i) begin
                    pc_d       = target_pc;
                    misalign_d = |branch_jump_addr_i[1:0];
                    flush_d    = 1'b1;
                    cnt_d      = 4'(FLUSH_CYCLES - 1);
                    req_d      = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    flush_d = 1'b0;
                    if (accept && !hold_pipeline_en_i) pc_d = pc_q + WIDTH'(4);
                end
            end
            ST_FLUSH: begin
                if (halt_i) begin
                    req_d    = 1'b0;
                    flush_d  = 1'b1;
                    halted_d = 1'b1;
                end else begin
                    req_d = 1'b1;
                    if (accept) pc_d = pc_q + WIDTH'(4);
                    if (cnt_q == 4'd0) flush_d = 1'b0;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
                req_d    = 1'b0;
                flush_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                flush_d = 1'b0;
            end
        endcase
    end

`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] redirect_cnt_q;
    logic        redirect_taken;

    assign redirect_taken = (state_q == ST_RUN) & ~halt_i & branch_jump_en_i;

    always_ff @(posedge clk) begin
        if (rst)                 redirect_cnt_q <= 32'd0;
        else if (redirect_taken) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end

    assign redirect_cnt_o = redirect_cnt_q;
`else
    assign redirect_cnt_o = 32'd0;
`endif

    // A held execute-stage request only freezes IF/ID while the controller is in RUN.
    assign stall_o = (req_q & ~fetch_ready_i)
                   | ((state_q == ST_RUN) & hold_pipeline_en_i & ~branch_jump_en_i);

    assign fetch_req_o = req_q;
    assign fetch_pc_o  = pc_q;
    assign flush_o     = flush_q;
    assign misalign_o  = misalign_q;
    assign halted_o    = halted_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus random traffic against a cycle-level model.
module tb_pc_redirect_ctrl;

    localparam int          FC  = 2;
    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst, bj, hold, halt, ready;
    logic [63:0] addr;
    logic        fetch_req_o, flush_o, stall_o, misalign_o, halted_o;
    logic [63:0] fetch_pc_o;
    logic [31:0] redirect_cnt_o;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    // Reference model: "flush_left" is how many more cycles flush_o stays high.
    logic [63:0] m_pc;
    bit          m_req, m_halted, m_mis;
    int          m_flush_left;
    logic [31:0] m_cnt;
    logic [63:0] exp_q[$];
    logic        stall_seen, exp_stall;

    pc_redirect_ctrl #(.WIDTH(64), .RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .branch_jump_en_i(bj), .branch_jump_addr_i(addr),
        .hold_pipeline_en_i(hold), .halt_i(halt), .fetch_ready_i(ready),
        .fetch_req_o(fetch_req_o), .fetch_pc_o(fetch_pc_o), .flush_o(flush_o),
        .stall_o(stall_o), .misalign_o(misalign_o), .halted_o(halted_o),
        .redirect_cnt_o(redirect_cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic bit m_in_flush();
        return !m_halted && (m_flush_left > 0) && (FC > 1);
    endfunction

    function automatic logic [1:0] m_state();
        if (m_halted)     return 2'd2;
        if (m_in_flush()) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        return (m_req && !ready) || (!m_halted && !m_in_flush() && hold && !bj);
    endfunction

    task automatic model_step();
        bit acc;
        bit win;
        acc = m_req && ready;
        win = m_in_flush();
        if (rst) begin
            m_pc = RPC; m_req = 0; m_flush_left = 0; m_halted = 0; m_mis = 0; m_cnt = 0;
        end else if (m_halted) begin
            m_req = 0; m_mis = 0;
            if (m_flush_left > 0) m_flush_left--;
        end else if (halt) begin
            m_halted = 1; m_req = 0; m_mis = 0; m_flush_left = 1;
        end else if (bj && !win) begin
            m_pc = addr & ~64'd3;
            m_mis = (addr[1:0] != 2'b00);
            m_flush_left = FC;
            m_req = 1;
`ifdef PC_REDIRECT_PERF_EN
            m_cnt = m_cnt + 32'd1;
`endif
        end else begin
            if (acc && !(hold && !win)) m_pc = m_pc + 64'd4;
            m_req = 1; m_mis = 0;
            if (m_flush_left > 0) m_flush_left--;
        end
    endtask

    task automatic tick(input logic r, input logic b, input logic [63:0] a,
                        input logic h, input logic hl, input logic rd);
        rst = r; bj = b; addr = a; hold = h; halt = hl; ready = rd;
        #1;
        stall_seen = stall_o;
        exp_stall  = m_stall();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 64'h1234, 1, 1, 1);
        tick(1, 0, 64'h0, 0, 0, 1);
        total++; if (fetch_pc_o !== RPC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", fetch_pc_o, RPC); end
        total++; if (fetch_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", fetch_req_o); end
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
        total++; if (halted_o !== 1'b0 || misalign_o !== 1'b0) begin bad++; $display("FAIL reset_halt_mis got=%b%b exp=00", halted_o, misalign_o); end
        total++; if (redirect_cnt_o !== 32'd0 || state_o !== 2'd0) begin bad++; $display("FAIL reset_cnt_state got=%0d/%0d exp=0/0", redirect_cnt_o, state_o); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) exp_q.push_back(RPC + 64'(4 * i));
        for (int i = 0; i < 4; i++) begin
            logic [63:0] e;
            tick(0, 0, 64'h0, 0, 0, 1);
            e = exp_q.pop_front();
            total++; if (fetch_pc_o !== e || fetch_req_o !== 1'b1 || flush_o !== 1'b0) begin
                bad++; $display("FAIL seq_pc[%0d] got=%h req=%b flush=%b exp=%h req=1 flush=0", i, fetch_pc_o, fetch_req_o, flush_o, e);
            end
        end
    endtask

    task automatic test_stall();
        tick(0, 0, 64'h0, 0, 0, 1);
        total++; if (fetch_pc_o !== 64'h8000_0010) begin bad++; $display("FAIL stall_start got=%h exp=80000010", fetch_pc_o); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 64'h0, 0, 0, 0);
            total++; if (stall_seen !== 1'b1 || fetch_pc_o !== 64'h8000_0010) begin
                bad++; $display("FAIL stall_hold[%0d] stall=%b pc=%h exp stall=1 pc=80000010", i, stall_seen, fetch_pc_o);
            end
        end
        tick(0, 0, 64'h0, 0, 0, 1);
        total++; if (stall_seen !== 1'b0 || fetch_pc_o !== 64'h8000_0014) begin
            bad++; $display("FAIL stall_resume stall=%b pc=%h exp stall=0 pc=80000014", stall_seen, fetch_pc_o);
        end
    endtask

    task automatic test_redirect();
        int          flush_seen;
        logic [31:0] exp_cnt;
`ifdef PC_REDIRECT_PERF_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        flush_seen = 0;
        tick(0, 1, 64'h8000_0100, 0, 0, 1);
        flush_seen += int'(flush_o);
        total++; if (fetch_pc_o !== 64'h8000_0100 || state_o !== 2'd1) begin bad++; $display("FAIL redir_pc got=%h st=%0d exp=80000100 st=1", fetch_pc_o, state_o); end
        total++; if (redirect_cnt_o !== exp_cnt) begin bad++; $display("FAIL redir_cnt got=%0d exp=%0d", redirect_cnt_o, exp_cnt); end
        tick(0, 1, 64'h8000_0400, 1, 0, 1);
        flush_seen += int'(flush_o);
        total++; if (fetch_pc_o !== 64'h8000_0104 || stall_seen !== 1'b0) begin bad++; $display("FAIL redir_ignore pc=%h stall=%b exp=80000104 stall=0", fetch_pc_o, stall_seen); end
        tick(0, 0, 64'h0, 0, 0, 1);
        flush_seen += int'(flush_o);
        total++; if (fetch_pc_o !== 64'h8000_0108 || state_o !== 2'd0) begin bad++; $display("FAIL redir_after pc=%h st=%0d exp=80000108 st=0", fetch_pc_o, state_o); end
        total++; if (flush_seen !== FC) begin bad++; $display("FAIL redir_flush_len got=%0d exp=%0d", flush_seen, FC); end
        total++; if (redirect_cnt_o !== exp_cnt) begin bad++; $display("FAIL redir_cnt_flush got=%0d exp=%0d", redirect_cnt_o, exp_cnt); end
    endtask

    task automatic test_misalign();
        tick(0, 1, 64'h8000_0202, 0, 0, 0);
        total++; if (fetch_pc_o !== 64'h8000_0200 || misalign_o !== 1'b1) begin bad++; $display("FAIL mis_pulse pc=%h mis=%b exp=80000200 mis=1", fetch_pc_o, misalign_o); end
        tick(0, 0, 64'h0, 0, 0, 0);
        total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misalign_o); end
        tick(0, 0, 64'h0, 0, 0, 0);
    endtask

    task automatic test_hold();
        tick(0, 1, 64'h8000_0020, 0, 0, 0);
        tick(0, 0, 64'h0, 0, 0, 0);
        tick(0, 0, 64'h0, 0, 0, 0);
        total++; if (fetch_pc_o !== 64'h8000_0020 || flush_o !== 1'b0) begin bad++; $display("FAIL hold_setup pc=%h flush=%b exp=80000020 flush=0", fetch_pc_o, flush_o); end
        tick(0, 0, 64'h0, 1, 0, 1);
        total++; if (stall_seen !== 1'b1 || fetch_pc_o !== 64'h8000_0020 || flush_o !== 1'b0) begin
            bad++; $display("FAIL hold_stall stall=%b pc=%h flush=%b exp stall=1 pc=80000020 flush=0", stall_seen, fetch_pc_o, flush_o);
        end
        tick(0, 0, 64'h0, 0, 0, 1);
        total++; if (fetch_pc_o !== 64'h8000_0024) begin bad++; $display("FAIL hold_release got=%h exp=80000024", fetch_pc_o); end
    endtask

    task automatic test_wrap();
        tick(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        total++; if (fetch_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || misalign_o !== 1'b1) begin bad++; $display("FAIL wrap_target pc=%h mis=%b exp=fffffffffffffffc mis=1", fetch_pc_o, misalign_o); end
        tick(0, 0, 64'h0, 0, 0, 0);
        tick(0, 0, 64'h0, 0, 0, 0);
        tick(0, 0, 64'h0, 0, 0, 1);
        total++; if (fetch_pc_o !== 64'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", fetch_pc_o); end
    endtask

    task automatic test_halt();
        tick(0, 0, 64'h0, 0, 0, 1);
        tick(0, 1, 64'h8000_0300, 0, 1, 1);
        total++; if (fetch_req_o !== 1'b0 || fetch_pc_o !== 64'h4 || halted_o !== 1'b1 || flush_o !== 1'b1) begin
            bad++; $display("FAIL halt_entry req=%b pc=%h halted=%b flush=%b exp req=0 pc=4 halted=1 flush=1", fetch_req_o, fetch_pc_o, halted_o, flush_o);
        end
        tick(0, 1, 64'h8000_0500, 1, 0, 1);
        total++; if (flush_o !== 1'b0 || halted_o !== 1'b1 || fetch_pc_o !== 64'h4 || stall_seen !== 1'b0 || state_o !== 2'd2) begin
            bad++; $display("FAIL halt_stay flush=%b halted=%b pc=%h stall=%b st=%0d exp 0/1/4/0/2", flush_o, halted_o, fetch_pc_o, stall_seen, state_o);
        end
        tick(1, 0, 64'h0, 0, 0, 1);
        total++; if (fetch_pc_o !== RPC || halted_o !== 1'b0 || state_o !== 2'd0) begin
            bad++; $display("FAIL halt_reset pc=%h halted=%b st=%0d exp=%h 0 0", fetch_pc_o, halted_o, state_o, RPC);
        end
        tick(0, 0, 64'h0, 0, 0, 1);
        total++; if (fetch_req_o !== 1'b1 || fetch_pc_o !== RPC) begin bad++; $display("FAIL halt_restart req=%b pc=%h exp req=1 pc=%h", fetch_req_o, fetch_pc_o, RPC); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic        r, b, h, hl, rd;
            logic [63:0] a;
            r  = ($urandom_range(0, 99) < 2);
            b  = ($urandom_range(0, 99) < 15);
            h  = ($urandom_range(0, 99) < 15);
            hl = ($urandom_range(0, 99) < 2);
            rd = ($urandom_range(0, 99) < 70);
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a[63:8] = '1;
            tick(r, b, a, h, hl, rd);
            total++; if (fetch_pc_o !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, fetch_pc_o, m_pc); end
            total++; if (fetch_req_o !== m_req) begin bad++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, fetch_req_o, m_req); end
            total++; if (flush_o !== (m_flush_left > 0)) begin bad++; $display("FAIL rnd_flush[%0d] got=%b exp=%b", i, flush_o, m_flush_left > 0); end
            total++; if (misalign_o !== m_mis || halted_o !== m_halted) begin bad++; $display("FAIL rnd_mis_halt[%0d] got=%b%b exp=%b%b", i, misalign_o, halted_o, m_mis, m_halted); end
            total++; if (redirect_cnt_o !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, redirect_cnt_o, m_cnt); end
            total++; if (stall_seen !== exp_stall) begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, stall_seen, exp_stall); end
            total++; if (state_o !== m_state()) begin bad++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", i, state_o, m_state()); end
        end
    endtask

    initial begin
        rst = 1; bj = 0; addr = '0; hold = 0; halt = 0; ready = 0;
        m_pc = RPC; m_req = 0; m_halted = 0; m_mis = 0; m_flush_left = 0; m_cnt = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misalign();
        test_hold();
        test_wrap();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Consumer end of the execute stage's controller interface.
- Accepts branch_jump_en / branch_jump_addr / hold_pipeline_en plus an ebreak halt.
- Owns the architectural fetch PC, drives instruction-fetch requests, and generates multi-cycle flush and stall for the IF/ID and ID/EX pipeline registers.
- Sits between the execute stage and the fetch stage, replacing the free-running PC counter.

Parameters:
- WIDTH, 64, PC and branch address width.
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (legal range 1..15).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- branch_jump_en_i  input  1  redirect request from execute stage
- branch_jump_addr_i  input  WIDTH  redirect target
- hold_pipeline_en_i  input  1  one-cycle hold request from execute stage
- halt_i  input  1  ebreak retired; stop fetching
- fetch_ready_i  input  1  fetch memory accepts request this cycle
- fetch_req_o  output  1  fetch request valid
- fetch_pc_o  output  WIDTH  address of current fetch request
- flush_o  output  1  flush IF/ID and ID/EX registers
- stall_o  output  1  freeze IF/ID register (combinational)
- misalign_o  output  1  one-cycle pulse: redirect target had addr[1:0]!=0
- halted_o  output  1  controller in HALT
- redirect_cnt_o  output  32  count of accepted redirects (optional feature)

Behaviour:
- FSM states: RUN, FLUSH, HALT. All outputs are registered except stall_o.
- Reset (rst=1 at edge), from any state including mid-FLUSH:
  - state=RUN, fetch_pc_o=RESET_PC, fetch_req_o=0, flush_o=0, misalign_o=0, halted_o=0, flush counter=0, redirect_cnt_o=0.
  - fetch_req_o goes to 1 on the first edge with rst=0. fetch_pc_o holds RESET_PC until that request is accepted.
- Accept = fetch_req_o & fetch_ready_i. On accept with no higher-priority event, fetch_pc_o <= fetch_pc_o + 4, wrapping mod 2^WIDTH.
- Event priority, evaluated each edge: halt_i > branch_jump_en_i > hold_pipeline_en_i > accept.
- RUN, halt_i=1:
  - Next state HALT; fetch_req_o <= 0, flush_o <= 1 for one cycle, halted_o <= 1.
  - fetch_pc_o frozen. An accept in the same cycle is discarded.
- RUN, branch_jump_en_i=1:
  - fetch_pc_o <= {branch_jump_addr_i[WIDTH-1:2], 2'b00}.
  - misalign_o <= |branch_jump_addr_i[1:0].
  - flush_o <= 1; counter <= FLUSH_CYCLES-1; next state FLUSH (or stays RUN with flush_o pulsed once if FLUSH_CYCLES=1).
  - An accept in the same cycle is discarded; the target PC is not incremented.
  - hold_pipeline_en_i is ignored when branch_jump_en_i is high.
- RUN, hold_pipeline_en_i=1 only:
  - stall_o=1 that cycle; fetch_pc_o does not advance even on accept; no flush.
- stall_o = (fetch_req_o & ~fetch_ready_i) | (state==RUN & hold_pipeline_en_i & ~branch_jump_en_i).
- FLUSH:
  - flush_o stays 1; counter decrements each cycle; at counter==0, flush_o <= 0 and next state RUN. flush_o is high for exactly FLUSH_CYCLES cycles.
  - fetch_req_o stays 1 and fetch_pc_o advances normally on accept.
  - branch_jump_en_i and hold_pipeline_en_i are ignored: they originate from flushed instructions.
  - halt_i is honoured and moves to HALT.
- HALT:
  - fetch_req_o=0, flush_o=0 (after the entry cycle), halted_o=1. All inputs are ignored; the only exit is rst.
- misalign_o is high only on the cycle after the offending redirect.

Optional Feature:
- Macro: PC_REDIRECT_PERF_EN.
- Defined: redirect_cnt_o increments by 1 on every accepted redirect (branch_jump_en_i taken in RUN). It wraps 32'hFFFF_FFFF -> 0 and is cleared by rst.
- Undefined: no counter flops; redirect_cnt_o tied to 32'd0.

Test Plan:
- Reset then fetch_ready_i=1 for 4 cycles -> fetch_pc_o sequence 8000_0000, 8000_0004, 8000_0008, 8000_000C; flush_o=0.
- fetch_ready_i=0 for 3 cycles at PC 8000_0010 -> stall_o=1, fetch_pc_o held; resumes to 8000_0014 after ready returns.
- branch_jump_en_i=1, addr=8000_0100, with fetch_ready_i=1 the same cycle -> next fetch_pc_o=8000_0100 (not +4); flush_o high exactly 2 cycles; a branch_jump_en_i pulse during FLUSH has no effect; redirect_cnt_o=1 when PC_REDIRECT_PERF_EN is defined.
- Redirect to 8000_0202 -> fetch_pc_o=8000_0200, misalign_o one-cycle pulse.
- hold_pipeline_en_i=1 alone at PC 8000_0020 -> stall_o=1, PC stays 8000_0020 one cycle, no flush.
- halt_i together with branch_jump_en_i -> HALT, fetch_req_o=0, PC unchanged, halted_o=1. Then rst=1 for one cycle -> fetch_pc_o=8000_0000, halted_o=0, state RUN.
